seq_divider: RTL and testbench

Iterative restoring unsigned divider, the inverse of the team's combinational 4x4 array multiplier. It takes a 2N-bit dividend (the multiplier's product width) and an N-bit divisor, and returns a 2N-bit quotient and an N-bit remainder. It retires one quotient bit per clock and uses a start/ready input handshake and a valid/ready output handshake. It sits beside the multiplier in the arithmetic datapath and handles the divide step of multiply/divide test sequences.

---
 rtl/seq_divider_pkg.sv | 20 ++
 rtl/seq_divider_if.sv | 36 +++
 rtl/seq_divider_div_step.sv | 32 +++
 rtl/seq_divider.sv | 105 ++++++++++
 tb/tb_seq_divider.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// ============================================================================
// Module : seq_divider_pkg
// Brief  : Shared types and constants for the iterative restoring divider.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_divider_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
// ============================================================================
// Module : seq_divider_if
// Brief  : Start/ready request and valid/ready result bundle for seq_divider.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
);

  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           dbz;

  modport master (
    output start, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz
  );

endinterface

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring-division step (shift, trial subtract).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int N = 4
) (
  input  wire logic [N:0]   r,
  input  wire logic         q_in,
  input  wire logic [N-1:0] d,
  output logic      [N:0]   r_next,
  output logic              q_bit
);

  logic [N:0]   w_shift;
  logic [N+1:0] w_diff;
  logic         w_ge;

  assign w_shift = {r[N-1:0], q_in};
  assign w_diff  = {1'b0, w_shift} - {2'b00, d};
  // A set r[N] means the shifted value exceeds any N-bit divisor.
  assign w_ge    = r[N] | ~w_diff[N+1];

  assign q_bit  = w_ge;
  assign r_next = w_ge ? w_diff[N:0] : w_shift;

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module : seq_divider
// Brief  : Iterative restoring unsigned divider, 2N/N -> 2N quotient, N rem.
//          Optional macro DIV_ZERO_CHECK_EN: zero-divisor early exit with dbz.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(2*N+1);
  localparam logic [1:0]    C_IDLE = IDLE;
  localparam logic [1:0]    C_RUN  = RUN;
  localparam logic [1:0]    C_DONE = DONE;
  localparam logic [CW-1:0] C_LAST = CW'(2*N-1);

  logic [1:0]     r_state;
  logic [2*N-1:0] r_q;
  logic [N:0]     r_rem;
  logic [N-1:0]   r_d;
  logic [CW-1:0]  r_cnt;
  logic [N:0]     w_rnext;
  logic           w_qbit;

  div_step #(.N(N)) u_step (
    .r      (r_rem),
    .q_in   (r_q[2*N-1]),
    .d      (r_d),
    .r_next (w_rnext),
    .q_bit  (w_qbit)
  );

`ifdef DIV_ZERO_CHECK_EN
  logic r_dbz;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
`ifdef DIV_ZERO_CHECK_EN
      r_dbz   <= 1'b0;
`endif
    end else begin
      case (r_state)
        C_IDLE: begin
          if (bus.start) begin
            r_q     <= bus.dividend;
            r_rem   <= '0;
            r_d     <= bus.divisor;
            r_cnt   <= '0;
            r_state <= C_RUN;
`ifdef DIV_ZERO_CHECK_EN
            r_dbz   <= (bus.divisor == '0);
`endif
          end
        end
        C_RUN: begin
`ifdef DIV_ZERO_CHECK_EN
          if (r_dbz) begin
            // Dividend still sits untouched in r_q on the first RUN cycle.
            r_q     <= '1;
            r_rem   <= {1'b0, r_q[N-1:0]};
            r_state <= C_DONE;
          end else
`endif
          begin
            r_q   <= {r_q[2*N-2:0], w_qbit};
            r_rem <= w_rnext;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == C_LAST) r_state <= C_DONE;
          end
        end
        C_DONE: begin
          if (bus.out_ready) r_state <= C_IDLE;
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == C_IDLE);
  assign bus.out_valid = (r_state == C_DONE);
  assign bus.quotient  = r_q;
  assign bus.remainder = r_rem[N-1:0];
`ifdef DIV_ZERO_CHECK_EN
  assign bus.dbz       = r_dbz;
`else
  assign bus.dbz       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module : tb_seq_divider
// Brief  : Scoreboard bench for seq_divider (N=4), honours DIV_ZERO_CHECK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  seq_divider_if #(.N(4)) bus ();

  seq_divider #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [7:0] dvd, input logic [3:0] dsr);
    exp_t e;
    if (dsr == 4'd0) begin
      e.q = 8'hFF;
      e.r = dvd[3:0];
`ifdef DIV_ZERO_CHECK_EN
      e.dbz = 1'b1;
      e.lat = 1;
`else
      e.dbz = 1'b0;
      e.lat = 8;
`endif
    end else begin
      e.q   = dvd / {4'd0, dsr};
      e.r   = 4'(dvd % {4'd0, dsr});
      e.dbz = 1'b0;
      e.lat = 8;
    end
    return e;
  endfunction

  task automatic do_div(input logic [7:0] dvd, input logic [3:0] dsr, input int hold, input bit pulse);
    exp_t e;
    int   lat;
    int   w;
    logic [7:0] q0;
    logic [3:0] r0;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_val("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dsr;
    sb.push_back(model(dvd, dsr));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check_val("in_ready_after_accept", {31'd0, bus.in_ready}, 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      if (pulse && lat == 2) begin
        bus.start    = 1'b1;
        bus.dividend = 8'h11;
        bus.divisor  = 4'h3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_val("out_valid_rise", {31'd0, bus.out_valid}, 32'd1);
    if (sb.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check_val("latency", 32'(lat), 32'(e.lat));
    check_val("quotient", {24'd0, bus.quotient}, {24'd0, e.q});
    check_val("remainder", {28'd0, bus.remainder}, {28'd0, e.r});
    check_val("dbz", {31'd0, bus.dbz}, {31'd0, e.dbz});
    q0 = bus.quotient;
    r0 = bus.remainder;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check_val("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check_val("hold_quotient", {24'd0, bus.quotient}, {24'd0, q0});
      check_val("hold_remainder", {28'd0, bus.remainder}, {28'd0, r0});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val("release_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    if (pulse) begin
      // A start seen during RUN must not have been queued.
      @(posedge clk);
      @(negedge clk);
      check_val("no_queued_start", {31'd0, bus.in_ready}, 32'd1);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("rst_dbz", {31'd0, bus.dbz}, 32'd0);
    check_val("rst_quotient", {24'd0, bus.quotient}, 32'd0);
    check_val("rst_remainder", {28'd0, bus.remainder}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_div(8'd200, 4'd13, 0, 1'b0);
    do_div(8'd255, 4'd1,  0, 1'b0);
    do_div(8'd7,   4'd9,  0, 1'b0);
    do_div(8'hA7,  4'd0,  0, 1'b0);
    do_div(8'd100, 4'd7,  5, 1'b1);
    do_div(8'd0,   4'd15, 0, 1'b0);

    // Abort 225/15 after three steps with an asynchronous reset.
    bus.start    = 1'b1;
    bus.dividend = 8'd225;
    bus.divisor  = 4'd15;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_val("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("abort_quotient", {24'd0, bus.quotient}, 32'd0);
    check_val("abort_remainder", {28'd0, bus.remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_div(8'd225, 4'd15, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_div(8'($urandom_range(0, 255)), 4'($urandom_range(1, 15)), 0, 1'b0);
    end

    check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
